// File: rtl/clarvi_pio_pkg.sv
// Shared definitions for the Clarvi PIO blocks: register addresses,
// edge-type encoding and debounce counter sizing.
package clarvi_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_RAW     = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        RISING  = 2'd0,
        FALLING = 2'd1,
        ANY     = 2'd2
    } edge_type_e;

    function automatic int counter_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/clarvi_pio_debounce.sv
// Single-bit debouncer: a change on sync is accepted into stable only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
module clarvi_pio_debounce
    import clarvi_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic stable
);

    localparam int            CW   = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            count  <= '0;
        end else if (count == LAST) begin
            stable <= sync;
            count  <= '0;
        end else begin
            count  <= count + CW'(1);
        end
    end

endmodule

// File: rtl/clarvi_pio_in_edge.sv
// Avalon-MM edge-capturing input port: synchroniser, optional debounce
// (enabled by defining CLARVI_PIO_DEBOUNCE_EN), sticky edge flags and IRQ.
module clarvi_pio_in_edge
    import clarvi_pio_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

`ifdef CLARVI_PIO_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    // Capture stays off until a level present at reset has worked its way
    // through the synchroniser and debouncer into both stable and prev.
    localparam int         ARM  = SYNC_STAGES + 1 + (DEBOUNCE_EN ? DEBOUNCE_CYCLES : 0);
    localparam int         AW   = $clog2(ARM + 1);
    localparam edge_type_e EDGE = edge_type_e'(EDGE_TYPE);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] raw, stable, prev_q, irqmask_q, edgecap_q, hit, clear;
    logic [AW-1:0]    arm_q;
    logic             armed;
    logic [31:0]      rd_mux;

    assign raw   = sync_q[SYNC_STAGES-1];
    assign armed = (arm_q == AW'(ARM));

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end

`ifdef CLARVI_PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        clarvi_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .sync  (raw[i]),
            .stable(stable[i])
        );
    end
`else
    assign stable = raw;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch cannot be inferred.
    always_comb begin
        hit    = '0;
        clear  = '0;
        rd_mux = '0;
        case (EDGE)
            RISING:  hit = stable & ~prev_q;
            FALLING: hit = ~stable & prev_q;
            default: hit = stable ^ prev_q;
        endcase
        if (write && address == PIO_ADDR_EDGECAP) clear = writedata[WIDTH-1:0];
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_RAW:     rd_mux[WIDTH-1:0] = raw;
            default:          rd_mux[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
            arm_q     <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            prev_q <= stable;
            if (!armed) arm_q <= arm_q + AW'(1);
            if (write && address == PIO_ADDR_IRQMASK) irqmask_q <= writedata[WIDTH-1:0];
            // A new edge on the same cycle as a W1C keeps the flag set.
            edgecap_q <= (edgecap_q & ~clear) | (armed ? hit : '0);
            irq       <= |(edgecap_q & irqmask_q);
            readdata  <= rd_mux;
        end
    end

    if (WIDTH < 32) begin : g_pad
        logic unused_writedata;
        assign unused_writedata = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_clarvi_pio_in_edge.sv
// Directed scoreboard bench for clarvi_pio_in_edge: a 16-bit rising-edge port
// and a 32-bit any-edge port share one bus and clock.
module tb_clarvi_pio_in_edge;

    localparam int S = 2;
`ifdef CLARVI_PIO_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif
    // Edges from in_port being sampled to the edge flag being set.
    localparam int L = S + D;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [15:0] in16;
    logic [31:0] in32;
    logic [31:0] rd16, rd32;
    logic        irq16, irq32;

    always #5 clk = ~clk;

    clarvi_pio_in_edge #(
        .WIDTH(16), .SYNC_STAGES(S), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .readdata(rd16), .in_port(in16), .irq(irq16)
    );

    clarvi_pio_in_edge #(
        .WIDTH(32), .SYNC_STAGES(S), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)
    ) dut32 (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .readdata(rd32), .in_port(in32), .irq(irq32)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_underflow: observed=%h", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step(1);
        write     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; address = 2'd0; write = 1'b0; writedata = '0;
        in16  = 16'hFFFF; in32 = '0;

        // Reset state while reset is held
        expect_val("rst_readdata", 32'h0);
        expect_val("rst_irq", 32'h0);
        expect_val("rst_readdata32", 32'h0);
        expect_val("rst_irq32", 32'h0);
        step(2);
        check(rd16); check({31'b0, irq16}); check(rd32); check({31'b0, irq32});

        // Inputs high through reset: arming must hide the apparent rise
        reset = 1'b0;
        step(20);
        expect_val("arm_data", 32'h0000_FFFF);
        address = 2'd0; step(1); check(rd16);
        expect_val("arm_edgecap", 32'h0);
        expect_val("arm_irq", 32'h0);
        address = 2'd3; step(1); check(rd16); check({31'b0, irq16});

        // Falling edges are not captured in rising mode
        expect_val("fall_ignored", 32'h0);
        in16 = 16'h0000; step(L + 4); check(rd16);
        expect_val("fall_data", 32'h0);
        address = 2'd0; step(1); check(rd16);

        // Mask write: only WIDTH bits stick
        expect_val("irqmask_rb", 32'h0000_0001);
        bus_write(2'd1, 32'hFFFF_0001);
        address = 2'd1; step(1); check(rd16);

        // Latency of bit0 rise to flag and irq
        address = 2'd3; step(1);
        expect_val("lat_irq_early", 32'h0);
        expect_val("lat_cap_early", 32'h0);
        in16 = 16'h0001; step(L + 1);
        check({31'b0, irq16}); check(rd16);
        expect_val("lat_irq", 32'h1);
        expect_val("lat_cap", 32'h1);
        step(1);
        check({31'b0, irq16}); check(rd16);

        // W1C on the same edge a new rising edge lands: set wins
        expect_val("irq_sticky", 32'h1);
        in16 = 16'h0000; step(L + 4); check({31'b0, irq16});
        expect_val("w1c_race_cap", 32'h1);
        expect_val("w1c_race_irq", 32'h1);
        in16 = 16'h0001; step(L);
        bus_write(2'd3, 32'h1);
        step(1);
        check(rd16); check({31'b0, irq16});

        // Mask and clear
        expect_val("cap_0x5", 32'h5);
        in16 = 16'h0005; step(L + 3);
        address = 2'd3; step(1); check(rd16);
        expect_val("irq_mask4", 32'h1);
        bus_write(2'd1, 32'h4); step(1); check({31'b0, irq16});
        expect_val("irq_mask_off_lag", 32'h1);
        expect_val("irq_mask_off", 32'h0);
        bus_write(2'd1, 32'h0); check({31'b0, irq16});
        step(1); check({31'b0, irq16});
        expect_val("w1c_clear", 32'h0);
        bus_write(2'd3, 32'h5); step(1); check(rd16);

        // Three-cycle glitch on bit3
        expect_val("raw_pulse", 32'h0000_000D);
        address = 2'd2;
        in16 = 16'h000D; step(3); check(rd16);
        in16 = 16'h0005; step(10);
        expect_val("glitch_data", 32'h0000_0005);
        address = 2'd0; step(1); check(rd16);
        expect_val("glitch_cap", (D > 0) ? 32'h0 : 32'h8);
        address = 2'd3; step(1); check(rd16);

        // Mid-operation reset with inputs high
        bus_write(2'd1, 32'h8);
        reset = 1'b1; step(1); reset = 1'b0;
        step(20);
        expect_val("midrst_mask", 32'h0);
        address = 2'd1; step(1); check(rd16);
        expect_val("midrst_cap", 32'h0);
        expect_val("midrst_irq", 32'h0);
        address = 2'd3; step(1); check(rd16); check({31'b0, irq16});
        expect_val("midrst_data", 32'h5);
        address = 2'd0; step(1); check(rd16);

        // 32-bit any-edge port on bit31
        expect_val("any_rise", 32'h8000_0000);
        in32 = 32'h8000_0000; step(L + 3);
        address = 2'd3; step(1); check(rd32);
        expect_val("any_clear", 32'h0);
        bus_write(2'd3, 32'h8000_0000); step(1); check(rd32);
        expect_val("any_fall", 32'h8000_0000);
        in32 = 32'h0; step(L + 3); check(rd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clarvi_pio_in_edge.md
Name: clarvi_pio_in_edge

Overview:
Parametrised Avalon-MM slave input port for the Clarvi SoC: successor to the fixed 16-bit button input. Synchronises an asynchronous input bus, optionally debounces it, captures edges per bit into sticky flags and raises a maskable interrupt. Sits on the Clarvi data bus alongside the other PIOs, driving buttons, switches and external status lines into software.

Parameters:
WIDTH, 16, input bus width; 1..32
SYNC_STAGES, 2, synchroniser flops per bit; 2..4
EDGE_TYPE, 0, capture on 0 = rising, 1 = falling, 2 = any edge
DEBOUNCE_CYCLES, 4, consecutive differing cycles needed to accept a change; >= 1; used only with debounce built in

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
address  input  2  Avalon word address
write  input  1  Avalon write strobe
writedata  input  32  Avalon write data
readdata  output  32  Avalon read data, registered
in_port  input  WIDTH  asynchronous external inputs
irq  output  1  level interrupt to the CPU

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on reset. All state clears on a clk edge with reset=1.
- Reset values: readdata=0, irq=0, sync chain=0, stable=0, irqmask=0, edgecapture=0, debounce counters=0, arm counter=0.
- Register map (readdata[31:WIDTH] always 0):
  - 0 DATA: stable value, RO.
  - 1 IRQMASK: RW, WIDTH bits.
  - 2 RAW: last synchroniser stage, RO.
  - 3 EDGECAP: read returns flags; write clears each bit where writedata=1 (W1C).
- Writes to addresses 0 and 2 are ignored.
- Read latency is 1. readdata is loaded every cycle from the mux at the current address. Reads have no side effects.
- Synchroniser: in_port is sampled at edge k. The last stage is valid after edge k+SYNC_STAGES-1.
- Debounce, per bit:
  - If sync != stable, the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and counter <= 0.
  - If sync == stable, counter <= 0. A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
- Edge detect: prev <= stable every cycle. The edge condition per EDGE_TYPE is evaluated on (prev, stable), and edgecapture bit <= 1 on the following edge.
- Simultaneous W1C and new edge on the same bit: the set wins.
- Arming: after reset, an arm counter counts up to ARM = SYNC_STAGES + DEBOUNCE_CYCLES + 1 (without debounce: SYNC_STAGES + 1), then saturates.
  - While arm < ARM, edge capture is suppressed; stable and prev still track the input.
  - This prevents spurious edges from inputs that are high at reset.
- irq is registered: irq <= |(edgecapture & irqmask) each cycle. It stays high until software clears the flags or the mask.
- Mid-operation reset: all flags, mask and counters clear, and the block re-arms.

Optional Feature:
Macro CLARVI_PIO_DEBOUNCE_EN.
- Defined: per-bit debounce counters are present as described.
- Undefined: stable = last synchroniser stage, directly. DEBOUNCE_CYCLES is ignored, no counters are instantiated, and ARM = SYNC_STAGES + 1.

Decomposition:
- Shared package clarvi_pio_pkg holds:
  - address constants PIO_ADDR_DATA/IRQMASK/RAW/EDGECAP;
  - an edge_type_e enum (RISING, FALLING, ANY);
  - a function for counter width, $clog2(DEBOUNCE_CYCLES+1).
- One natural sub-module: clarvi_pio_debounce, a single-bit counter debouncer instantiated WIDTH times under the macro.

Test Plan:
- Reset: assert reset with in_port=16'hFFFF, release, wait 20 cycles -> DATA=0x0000FFFF, EDGECAP=0, irq=0 (arming suppresses edges).
- Latency (debounce on, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, mask=0x1): bit0 rises, sampled at edge k -> stable at edge k+5, EDGECAP[0] at edge k+6, irq at edge k+7. Debounce off: EDGECAP[0] at k+2, irq at k+3.
- Glitch: bit3 high for 3 cycles then low (debounce on) -> DATA[3] stays 0, EDGECAP=0, RAW shows the pulse.
- W1C race: write 0x1 to address 3 on the same edge a new rising edge on bit0 is captured -> EDGECAP[0] remains 1, irq stays 1.
- Mask and clear: EDGECAP=0x5, IRQMASK=0x4 -> irq=1; write IRQMASK=0 -> irq=0 one cycle later; write 0x5 to address 3 -> EDGECAP=0.
- EDGE_TYPE=2, WIDTH=32: toggle bit31 up then down -> EDGECAP[31] set after each edge; readdata returns 0x80000000 at address 3 one cycle after the address is presented.
